// File: rtl/ofm_drain.sv
// -----------------------------------------------------------------------------
// ofm_drain
//   Read-side drain for the packed output feature-map buffer (port B).
//   A start pulse latches a base address and a word count; the block then reads
//   each 64-bit word, splits it into LANES psums (lane 0 = most significant
//   slice, sent first) and streams them out over a valid/ready handshake.
//   Counterpart of the data_pack -> out_buf write path.
//
// Optional feature (compile-time macro):
//   OFM_DRAIN_RELU_EN  - lanes are treated as signed; negative psums are
//                        output as zero. Undefined: lanes pass bit-exact.
//
// Parameters
//   ADDR_W   buffer address width
//   DATA_W   buffer word width, must equal LANES*LANE_W
//   LANE_W   psum width
//   LANES    psums per word
//   CNT_W    word-count width
//   READ_LAT buffer read latency in cycles (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   1-cycle request, sampled only in IDLE
//   base_addr  in   first word address, latched on start
//   num_words  in   words to drain, latched on start
//   busy       out  high in every state except IDLE
//   done       out  1-cycle pulse when the drain completes
//   mem_en     out  buffer port-B enable
//   mem_addr   out  buffer port-B address
//   mem_dout   in   buffer port-B read data
//   out_valid  out  psum valid
//   out_ready  in   sink accept
//   out_data   out  psum
//   out_last   out  final psum of the drain
// -----------------------------------------------------------------------------
module ofm_drain #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 64,
   parameter int LANE_W   = 16,
   parameter int LANES    = 4,
   parameter int CNT_W    = 16,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_data,
   output logic              out_last
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_EMIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int WAIT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   logic [2:0]         state;
   logic [ADDR_W-1:0]  addr;
   logic [CNT_W-1:0]   words_left;
   logic [LANE_IW-1:0] lane;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0]  word;

   logic wait_last;
   assign wait_last = (wait_cnt == WAIT_W'(READ_LAT - 1));

   // Slice lane idx out of a word (lane 0 = top bits) and apply the optional
   // clamp, so the clamp costs no extra pipeline stage.
   function automatic logic [LANE_W-1:0] lane_sel(input logic [DATA_W-1:0] w,
                                                  input int unsigned       idx);
      logic [DATA_W-1:0] sh;
      logic [LANE_W-1:0] v;
      sh = w >> ((LANES - 1 - idx) * LANE_W);
      v  = sh[LANE_W-1:0];
`ifdef OFM_DRAIN_RELU_EN
      if (v[LANE_W-1]) v = '0;
`endif
      return v;
   endfunction

   // NOTE: the captured word is pure datapath and is only consumed in EMIT,
   // after it has been loaded, so it is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (state == S_WAIT && wait_last) word <= mem_dout;
   end

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         words_left <= '0;
         lane       <= '0;
         wait_cnt   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
      end else begin
         // Single-cycle strobes default low.
         done   <= 1'b0;
         mem_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_words != '0) begin
                     addr       <= base_addr;
                     words_left <= num_words;
                     mem_addr   <= base_addr;
                     mem_en     <= 1'b1;
                     state      <= S_RD;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_RD: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_last) begin
                  lane      <= '0;
                  out_valid <= 1'b1;
                  out_data  <= lane_sel(mem_dout, 0);
                  out_last  <= (LANES == 1) && (words_left == CNT_W'(1));
                  state     <= S_EMIT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_EMIT: begin
               // out_valid is always high here; without ready everything holds.
               if (out_ready) begin
                  if (lane != LANE_IW'(LANES - 1)) begin
                     lane     <= lane + LANE_IW'(1);
                     out_data <= lane_sel(word, int'(lane) + 1);
                     out_last <= (int'(lane) + 1 == LANES - 1) &&
                                 (words_left == CNT_W'(1));
                  end else begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (words_left == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        // Address wraps naturally modulo 2^ADDR_W.
                        addr       <= addr + ADDR_W'(1);
                        mem_addr   <= addr + ADDR_W'(1);
                        mem_en     <= 1'b1;
                        words_left <= words_left - CNT_W'(1);
                        state      <= S_RD;
                     end
                  end
               end
            end
            S_DONE: begin
               // start is not looked at here, so a request coinciding with
               // the return to IDLE is dropped.
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy      <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ofm_drain.sv
// -----------------------------------------------------------------------------
// tb_ofm_drain
//   Scoreboard bench for ofm_drain. Each accepted start pushes the expected
//   read addresses and psums (derived from the buffer contents) into queues;
//   a negedge monitor pops and compares whenever the DUT reads or transfers.
// -----------------------------------------------------------------------------
module tb_ofm_drain;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 64;
   localparam int LANE_W = 16;
   localparam int LANES  = 4;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  num_words = '0;
   logic              busy, done, mem_en, out_valid, out_last;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_dout;
   logic              out_ready = 1'b0;
   logic [LANE_W-1:0] out_data;

   ofm_drain dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   // Buffer model, read latency 1.
   logic [DATA_W-1:0] mem [0:65535];
   always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

   typedef struct packed {
      logic [LANE_W-1:0] data;
      logic              last;
   } psum_t;

   psum_t             exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];

   int n_checks  = 0;
   int n_fail    = 0;
   int done_seen = 0;
   int exp_done  = 0;
   int psum_cnt  = 0;
   bit done_due  = 0;
   int rdy_mode  = 0;
   int rdy_phase = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: lane k is the k-th 16-bit slice counted from the top.
   function automatic logic [LANE_W-1:0] ref_psum(input logic [DATA_W-1:0] w, input int k);
      logic [LANE_W-1:0] v;
      v = w[DATA_W-1-LANE_W*k -: LANE_W];
`ifdef OFM_DRAIN_RELU_EN
      if ($signed(v) < 0) v = '0;
`endif
      return v;
   endfunction

   task automatic push_drain(input logic [ADDR_W-1:0] base, input int num);
      for (int w = 0; w < num; w++) begin
         logic [ADDR_W-1:0] a;
         a = base + ADDR_W'(w);
         addr_q.push_back(a);
         for (int k = 0; k < LANES; k++) begin
            psum_t p;
            p.data = ref_psum(mem[a], k);
            p.last = (w == num - 1) && (k == LANES - 1);
            exp_q.push_back(p);
         end
      end
      exp_done++;
   endtask

   // Returns at posedge+1 just after the edge that sampled start.
   task automatic pulse_start(input logic [ADDR_W-1:0] base, input int num);
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = base;
      num_words = CNT_W'(num);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int i;
      i = 0;
      while (done_seen < exp_done && i < 2000) begin
         @(posedge clk);
         i++;
      end
      check({tag, "_timeout"}, 64'(done_seen >= exp_done), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_done_count"}, 64'(done_seen), 64'(exp_done));
      check({tag, "_psums_left"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_reads_left"}, 64'(addr_q.size()), 64'd0);
   endtask

   task automatic wait_psums(input int target);
      int i;
      i = 0;
      while (psum_cnt < target && i < 500) begin
         @(posedge clk); #1;
         i++;
      end
      check("wait_psums_timeout", 64'(psum_cnt >= target), 64'd1);
   endtask

   // Sink ready pattern, changed just after each rising edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (rdy_phase % 3 == 0);
               rdy_phase++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: mid-cycle sampling of reads, transfers, holds and done.
   initial begin
      bit    held_v;
      psum_t held;
      psum_t e;
      held_v = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 0;
         end else begin
            if (done_due) begin
               check("done_after_last", 64'(done), 64'd1);
               done_due = 0;
            end
            if (mem_en) begin
               if (addr_q.size() == 0) check("unexpected_mem_en", 64'd1, 64'd0);
               else check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            end
            if (held_v) begin
               check("valid_hold", 64'(out_valid), 64'd1);
               if (out_valid) check("data_hold", 64'({out_data, out_last}), 64'(held));
            end
            held_v = 0;
            if (out_valid) begin
               if (out_ready) begin
                  psum_cnt++;
                  if (exp_q.size() == 0) begin
                     check("unexpected_psum", 64'd1, 64'd0);
                  end else begin
                     e = exp_q.pop_front();
                     check("out_data", 64'(out_data), 64'(e.data));
                     check("out_last", 64'(out_last), 64'(e.last));
                     if (e.last) done_due = 1;
                  end
               end else begin
                  held_v = 1;
                  held   = {out_data, out_last};
               end
            end
            if (done) done_seen++;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int base_cnt;
      for (int i = 0; i < 65536; i++) mem[i] = {$urandom, $urandom};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_mem_en", 64'(mem_en), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1. Basic drain with cycle timing
      mem[16'h0010] = 64'h0001_0002_FFFF_8000;
      rdy_mode = 0;
      push_drain(16'h0010, 1);
      pulse_start(16'h0010, 1);
      @(negedge clk);
      check("t1_c1_mem_en", 64'(mem_en), 64'd1);
      check("t1_c1_busy", 64'(busy), 64'd1);
      check("t1_c1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("t1_c2_mem_en", 64'(mem_en), 64'd0);
      check("t1_c2_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("t1_c3_valid", 64'(out_valid), 64'd1);
      c = 3;
      while (!done && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("t1_done_cycle", 64'(c), 64'd7);
      wait_done("t1");

      // 2. Backpressure, two words
      rdy_mode  = 1;
      rdy_phase = 0;
      push_drain(16'h0010, 2);
      pulse_start(16'h0010, 2);
      wait_done("t2");

      // 3. Zero count, plus a start during DONE that must be dropped
      rdy_mode = 0;
      exp_done++;
      pulse_start(16'h0020, 0);
      @(negedge clk);
      check("t3_done", 64'(done), 64'd1);
      check("t3_busy", 64'(busy), 64'd1);
      start     = 1'b1;
      base_addr = 16'h0030;
      num_words = 16'd1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("t3_idle_busy", 64'(busy), 64'd0);
      check("t3_done_pulse", 64'(done), 64'd0);
      wait_done("t3");

      // 4. Address wrap with an ignored mid-drain start
      rdy_mode = 2;
      base_cnt = psum_cnt;
      push_drain(16'hFFFF, 2);
      pulse_start(16'hFFFF, 2);
      wait_psums(base_cnt + 3);
      pulse_start(16'h1234, 5);
      wait_done("t4");

      // 5. Reset during EMIT lane 2
      rdy_mode = 0;
      base_cnt = psum_cnt;
      push_drain(16'h0040, 2);
      pulse_start(16'h0040, 2);
      wait_psums(base_cnt + 2);
      rst = 1'b1;
      exp_q.delete();
      addr_q.delete();
      done_due = 0;
      exp_done = done_seen;
      @(posedge clk);
      @(negedge clk);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_valid", 64'(out_valid), 64'd0);
      check("t5_done", 64'(done), 64'd0);
      rst = 1'b0;
      push_drain(16'h0041, 1);
      pulse_start(16'h0041, 1);
      wait_done("t5");

      // 6. Sign-bit lanes (clamped only under the RELU build)
      mem[16'h0050] = 64'h8000_7FFF_FFFF_0005;
      push_drain(16'h0050, 1);
      pulse_start(16'h0050, 1);
      wait_done("t6");

      // Randomised drains
      for (int r = 0; r < 10; r++) begin
         logic [ADDR_W-1:0] b;
         int n;
         b = ADDR_W'($urandom);
         n = $urandom_range(1, 4);
         rdy_mode = (r % 2 == 0) ? 2 : 0;
         push_drain(b, n);
         pulse_start(b, n);
         wait_done("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
